// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/prefetch front end.
// Latency: none, declarations only.
// Backpressure: not applicable.
package fetch_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int INSTR_W      = 32;

    // addi x0, x0, 0 -- presented on fetch_instr while nothing is buffered
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    // One prefetched instruction together with the PC it was fetched from
    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head and single-cycle flush.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; flush overrides both.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushDat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         headDat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    // qualify requests against occupancy; a flush cancels both
    always_comb begin
        doPush = push && !full && !flush;
        doPop  = pop && !empty && !flush;
    end

    // storage has no reset: entries are only observed while count marks them valid
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushDat;
        end
    end

    // pointers and occupancy, cleared by reset or flush
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

    // status flags and fall-through head
    always_comb begin
        empty   = (count == '0);
        full    = (count == FULL_CNT);
        headDat = mem[rdPtr];
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with prefetch FIFO over a variable-latency in-order imem interface.
// Latency: with a 1-cycle memory, fetch_valid rises 2 cycles after a request is accepted.
// Backpressure: stall_d holds the head; requests stop once in-flight plus buffered reaches DEPTH.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN            = DEFAULT_XLEN,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               stall_d,
    output logic               fetch_valid,
    output logic [XLEN-1:0]    fetch_pc,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic [XLEN-1:0]    fetch_pc_plus4
);

    localparam int              CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_C   = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]   MAX_OUT_C = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] reqPc;
    logic [XLEN-1:0] rspPc;
    logic [XLEN-1:0] redirectTarget;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   dropCnt;
    logic [CW-1:0]   fifoCount;
    logic [CW:0]     creditUsed;
    logic            reqFire;
    logic            rspFire;
    logic            fifoPush;
    logic            fifoPop;
    logic            fifoEmpty;
    logic            fifoFull;
    entry_t          pushEntry;
    entry_t          headEntry;
    logic [1:0]      unusedRedirectLsbs;

    // request issue: credits cover live responses still owed plus what is already buffered
    always_comb begin
        creditUsed     = {1'b0, outstanding} - {1'b0, dropCnt} + {1'b0, fifoCount};
        imem_req_valid = !reset && !redirect_valid
                         && (creditUsed < DEPTH_C)
                         && (outstanding < MAX_OUT_C);
        imem_req_addr  = reqPc;
        reqFire        = imem_req_valid && imem_req_ready;
    end

    // response acceptance, FIFO control and redirect target alignment
    always_comb begin
        // with nothing in flight a response can only be a leftover from before reset
        rspFire            = imem_rsp_valid && (outstanding != '0);
        fifoPush           = rspFire && (dropCnt == '0) && !redirect_valid;
        pushEntry          = '{pc: rspPc, instr: imem_rsp_data};
        fifoPop            = fetch_valid && !stall_d && !redirect_valid;
        redirectTarget     = {redirect_pc[XLEN-1:2], 2'b00};
        unusedRedirectLsbs = redirect_pc[1:0];
    end

    // request PC: steps on each accepted request, jumps to the aligned target on redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            reqPc <= RESET_PC;
        end else if (redirect_valid) begin
            reqPc <= redirectTarget;
        end else if (reqFire) begin
            reqPc <= reqPc + PC_STEP;
        end
    end

    // response PC: tags each kept response, so it only moves on a push
    always_ff @(posedge clk) begin
        if (reset) begin
            rspPc <= RESET_PC;
        end else if (redirect_valid) begin
            rspPc <= redirectTarget;
        end else if (fifoPush) begin
            rspPc <= rspPc + PC_STEP;
        end
    end

    // requests in flight at the memory, stale or live
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + CW'(reqFire) - CW'(rspFire);
        end
    end

    // stale responses still to discard; a response landing with the redirect is itself dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            dropCnt <= '0;
        end else if (redirect_valid) begin
            dropCnt <= outstanding - CW'(rspFire);
        end else if (rspFire && (dropCnt != '0)) begin
            dropCnt <= dropCnt - CNT_ONE;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifoPush),
        .pushDat (pushEntry),
        .pop     (fifoPop),
        .flush   (redirect_valid),
        .headDat (headEntry),
        .count   (fifoCount),
        .empty   (fifoEmpty),
        .full    (fifoFull)
    );

    // decode-facing head; a NOP is shown whenever nothing valid is buffered
    always_comb begin
        fetch_valid    = !fifoEmpty && !reset;
        fetch_pc       = headEntry.pc;
        fetch_instr    = fetch_valid ? headEntry.instr : NOP;
        fetch_pc_plus4 = headEntry.pc + PC_STEP;
    end

    // the credit scheme must leave room for every kept response
    aNoOverflow: assert property (@(posedge clk) disable iff (reset) fifoPush |-> !fifoFull);

    // discards can never exceed what is actually in flight
    aDropBound: assert property (@(posedge clk) disable iff (reset) dropCnt <= outstanding);

    // in-flight limit is respected
    aOutBound: assert property (@(posedge clk) disable iff (reset) outstanding <= MAX_OUT_C);

    // a refused request stays put until accepted or cancelled by redirect/reset
    aReqStable: assert property (@(posedge clk) disable iff (reset)
        (imem_req_valid && !imem_req_ready)
        |=> (redirect_valid || reset || (imem_req_valid && $stable(imem_req_addr))));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: vector table, directed corners, random traffic.
// Latency: memory model answers in order after a fixed or random delay of at least one cycle.
// Backpressure: imem_req_ready and stall_d are driven from per-phase probabilities.
module tb_fetch_prefetch_unit;

    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc_plus4;

    always #5 clk = ~clk;

    fetch_prefetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_d        (stall_d),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .fetch_pc_plus4 (fetch_pc_plus4)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } memReq_t;

    typedef struct {
        logic [31:0] redir;
        logic [31:0] first;
        logic [31:0] second;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cycle = 0;
    int          epoch = 0;
    int          liveInFlight = 0;
    int          buffered = 0;
    int          popCount = 0;
    int          memLat = 1;
    int          readyPct = 100;
    int          stallPct = 0;
    memReq_t     memQ[$];
    logic [31:0] popLog[$];
    logic [31:0] reqLog[$];
    logic [31:0] expReqPc;
    logic [31:0] expFetchPc;
    logic        obsReqValid;
    logic [31:0] obsReqAddr;
    logic        obsFetchValid;
    logic [31:0] obsFetchPc;
    vec_t        vecs[5];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a ^ 32'h1357_9BDF) + {a[7:0], a[31:8]};
    endfunction

    function automatic logic [31:0] b2w(input logic b);
        return {31'b0, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // one clock of traffic: drive at negedge, observe 1 time unit later, update the model
    task automatic step(input logic doRedirect, input logic [31:0] target);
        memReq_t r;
        logic    rspNow;
        logic    popNow;
        @(negedge clk);
        reset          = 1'b0;
        redirect_valid = doRedirect;
        redirect_pc    = target;
        imem_req_ready = ($urandom_range(99) < readyPct);
        stall_d        = ($urandom_range(99) < stallPct);
        rspNow         = (memQ.size() > 0) && (memQ[0].due <= cycle);
        imem_rsp_valid = rspNow;
        imem_rsp_data  = rspNow ? memWord(memQ[0].addr) : 32'h0;
        #1;
        obsReqValid   = imem_req_valid;
        obsReqAddr    = imem_req_addr;
        obsFetchValid = fetch_valid;
        obsFetchPc    = fetch_pc;
        if (fetch_valid) check("pc_plus4", fetch_pc_plus4, fetch_pc + 32'd4);
        if (doRedirect) check("no_req_on_redirect", b2w(imem_req_valid), 32'd0);
        if (rspNow) begin
            r = memQ.pop_front();
            if (r.epoch == epoch) begin
                liveInFlight--;
                if (!doRedirect) buffered++;
            end
        end
        popNow = fetch_valid && !stall_d && !doRedirect;
        if (popNow) begin
            check("fetch_pc", fetch_pc, expFetchPc);
            check("fetch_instr", fetch_instr, memWord(expFetchPc));
            popLog.push_back(fetch_pc);
            expFetchPc += 32'd4;
            buffered--;
            popCount++;
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, expReqPc);
            reqLog.push_back(imem_req_addr);
            r.addr  = imem_req_addr;
            r.due   = cycle + ((memLat > 0) ? memLat : int'($urandom_range(4, 1)));
            r.epoch = epoch;
            memQ.push_back(r);
            expReqPc += 32'd4;
            liveInFlight++;
        end
        if (doRedirect) begin
            epoch++;
            expReqPc     = {target[31:2], 2'b00};
            expFetchPc   = {target[31:2], 2'b00};
            liveInFlight = 0;
            buffered     = 0;
            popLog.delete();
            reqLog.delete();
        end
        check("credit_bound", b2w(liveInFlight + buffered <= DEPTH), 32'd1);
        check("max_outstanding", b2w(memQ.size() <= MAX_OUT), 32'd1);
        cycle++;
    endtask

    task automatic modelReset();
        memQ.delete();
        popLog.delete();
        reqLog.delete();
        epoch++;
        liveInFlight = 0;
        buffered     = 0;
        expReqPc     = RST_PC;
        expFetchPc   = RST_PC;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        stall_d        = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("rst_req_valid", b2w(imem_req_valid), 32'd0);
            check("rst_fetch_valid", b2w(fetch_valid), 32'd0);
            @(negedge clk);
        end
        modelReset();
    endtask

    initial begin
        int  snap;
        int  cnt;
        logic found;

        vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0204};
        vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'h8000_0005, 32'h8000_0004, 32'h8000_0008};
        vecs[4] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0004};

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; stall_d = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

        // startup latency and single-cycle throughput
        doReset();
        memLat = 1; readyPct = 100; stallPct = 0;
        step(1'b0, 32'h0);
        check("first_req_valid", b2w(obsReqValid), 32'd1);
        check("first_req_addr", obsReqAddr, RST_PC);
        step(1'b0, 32'h0);
        check("fv_not_yet", b2w(obsFetchValid), 32'd0);
        step(1'b0, 32'h0);
        check("fv_rise", b2w(obsFetchValid), 32'd1);
        check("fv_rise_pc", obsFetchPc, RST_PC);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0);
            if (obsFetchValid) cnt++;
        end
        check("throughput", cnt, 32'd10);

        // decode stall fills exactly DEPTH credits and delivers nothing
        stallPct = 100;
        snap = popCount;
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0);
        check("stall_fill", liveInFlight + buffered, DEPTH);
        check("stall_no_pop", popCount - snap, 32'd0);
        stallPct = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0);

        // 3-cycle memory, redirect with 0x8 and 0xC in flight
        doReset();
        memLat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (memQ.size() == 2 && memQ[0].addr == 32'h8 && memQ[1].addr == 32'hC && memQ[0].due > cycle)
                found = 1'b1;
            else
                step(1'b0, 32'h0);
        end
        check("reach_8_C_inflight", b2w(found), 32'd1);
        step(1'b1, 32'h0000_0100);
        for (int i = 0; i < 30 && popLog.size() == 0; i++) step(1'b0, 32'h0);
        check("redir_pop_seen", b2w(popLog.size() > 0), 32'd1);
        if (popLog.size() > 0) check("redir_first_pc", popLog[0], 32'h0000_0100);

        // redirect in the same cycle as a response with two in flight
        doReset();
        memLat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (memQ.size() == 2 && memQ[0].due <= cycle) found = 1'b1;
            else step(1'b0, 32'h0);
        end
        check("reach_coincident", b2w(found), 32'd1);
        step(1'b1, 32'h0000_0240);
        for (int i = 0; i < 30 && popLog.size() == 0; i++) step(1'b0, 32'h0);
        check("coinc_pop_seen", b2w(popLog.size() > 0), 32'd1);
        if (popLog.size() > 0) check("coinc_first_pc", popLog[0], 32'h0000_0240);

        // request held stable while memory refuses it
        doReset();
        memLat = 1; readyPct = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0);
            check("hold_valid", b2w(obsReqValid), 32'd1);
            check("hold_addr", obsReqAddr, RST_PC);
        end
        readyPct = 100;

        // reset with two in flight; leftover responses must be ignored
        doReset();
        memLat = 3;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        check("pre_reset_inflight", memQ.size(), 32'd2);
        @(negedge clk);
        reset = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = JUNK; imem_req_ready = 1'b0;
        #1;
        check("midrst_req_valid", b2w(imem_req_valid), 32'd0);
        check("midrst_fetch_valid", b2w(fetch_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = JUNK; imem_req_ready = 1'b0;
            #1;
            check("restart_addr", imem_req_addr, RST_PC);
            check("stale_no_fetch", b2w(fetch_valid), 32'd0);
        end
        modelReset();
        memLat = 1; readyPct = 100;
        for (int i = 0; i < 20 && popLog.size() == 0; i++) step(1'b0, 32'h0);
        check("restart_pop_seen", b2w(popLog.size() > 0), 32'd1);
        if (popLog.size() > 0) check("restart_first_pc", popLog[0], RST_PC);

        // table of redirect targets: alignment and wraparound
        doReset();
        memLat = 1; readyPct = 100; stallPct = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0);
        for (int v = 0; v < 5; v++) begin
            step(1'b1, vecs[v].redir);
            for (int i = 0; i < 30 && popLog.size() < 2; i++) step(1'b0, 32'h0);
            check("tbl_pops", b2w(popLog.size() >= 2), 32'd1);
            if (reqLog.size() > 0) check("tbl_first_req", reqLog[0], vecs[v].first);
            if (popLog.size() >= 2) begin
                check("tbl_first_pc", popLog[0], vecs[v].first);
                check("tbl_second_pc", popLog[1], vecs[v].second);
            end
        end

        // randomized traffic under several memory/decode behaviours
        for (int c = 0; c < 4; c++) begin
            doReset();
            case (c)
                0: begin memLat = 1; readyPct = 100; stallPct = 0;  end
                1: begin memLat = 0; readyPct = 70;  stallPct = 30; end
                2: begin memLat = 3; readyPct = 50;  stallPct = 10; end
                default: begin memLat = 0; readyPct = 90; stallPct = 60; end
            endcase
            snap = popCount;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(99) < 4) begin
                    if ($urandom_range(1) == 0) step(1'b1, $urandom);
                    else step(1'b1, 32'hFFFF_FFF0 + 32'($urandom_range(15)));
                end else begin
                    step(1'b0, 32'h0);
                end
            end
            check("random_progress", b2w(popCount - snap > 20), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised successor to the single-cycle IF stage of the 5-stage RV32I pipeline. It decouples fetch from decode through a prefetch FIFO and drives a variable-latency instruction-memory request/response interface. It also handles EX-stage redirects (taken branch or jump) correctly even while memory responses are still in flight. It sits between instruction memory and the IF/ID pipeline register; fetch_pc, fetch_instr and fetch_pc_plus4 replace the old PCF/InstrF/PCPlus4F.

Parameters:
XLEN, 32, address/PC width
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max imem requests in flight (>=1, <=DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
imem_req_valid  out  1  request address valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response data valid (in order, no backpressure)
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  PCSrcE: flush and refetch
redirect_pc  in  XLEN  PCTargetE
stall_d  in  1  decode not accepting (StallD)
fetch_valid  out  1  head entry valid
fetch_pc  out  XLEN  PC of head instruction
fetch_instr  out  32  head instruction
fetch_pc_plus4  out  XLEN  fetch_pc + 4

Behaviour:
- One clock, clk. reset is synchronous, active-high. While reset is high:
  - req_pc = rsp_pc = RESET_PC; outstanding = drop_cnt = 0; FIFO empty.
  - imem_req_valid = 0 and fetch_valid = 0.
- Issue condition: imem_req_valid = !reset & !redirect_valid & (outstanding - drop_cnt + count < DEPTH) & (outstanding < MAX_OUTSTANDING).
  - imem_req_addr = req_pc.
  - A request fires when valid & ready: req_pc += 4 and outstanding increments.
  - While ready is low, addr and valid stay stable.
- Responses arrive in request order, at least 1 cycle after acceptance. Each decrements outstanding.
  - If drop_cnt > 0: the response is discarded and drop_cnt decrements.
  - Otherwise {rsp_pc, data} is pushed and rsp_pc += 4.
  - imem_rsp_valid while outstanding == 0 is ignored; this covers stale responses after a mid-operation reset.
- Credit check guarantees the FIFO never overflows, so no push is ever refused.
- Output: fetch_valid = FIFO non-empty, with head fields driven combinationally.
  - Pop when fetch_valid & !stall_d & !redirect_valid.
- Redirect, evaluated in the cycle redirect_valid is high:
  - FIFO is cleared and no pop or push takes effect.
  - req_pc and rsp_pc are set to {redirect_pc[XLEN-1:2], 2'b00}; misaligned targets are truncated.
  - drop_cnt is set to outstanding - (imem_rsp_valid ? 1 : 0). A response arriving in the same cycle is itself discarded.
  - No request is issued in that cycle.
  - The first request to the new PC can go out on the next cycle.
- Back-to-back redirects: the last one wins. drop_cnt is recomputed each time and stays <= outstanding.
- Latency: with a 1-cycle memory and stall_d = 0:
  - The first request issues on the cycle after reset deasserts.
  - fetch_valid rises 2 cycles after that request is accepted.
  - Steady-state throughput is 1 instruction per cycle when MAX_OUTSTANDING >= 2.
- Width rules: PC arithmetic is modulo 2^XLEN, so wrap from 0xFFFF_FFFC to 0 is allowed. Counters are sized $clog2(DEPTH)+1.

Decomposition:
- Shared package (fetch_pkg): XLEN default, INSTR_W = 32, NOP = 32'h0000_0013, and the packed fetch_entry_t {pc, instr}.
- One sub-module, fetch_fifo: synchronous FIFO, parametrised DEPTH/WIDTH, with push/pop/flush inputs, count/empty/full outputs, and first-word-fall-through head.

Test Plan:
- Reset, ready = 1, 1-cycle memory, stall_d = 0 -> imem_req_addr 0,4,8,...; fetch_pc 0,4,8,... with one per cycle after startup; fetch_pc_plus4 = fetch_pc + 4.
- stall_d held high for 8 cycles -> at most 4 instructions buffered or in flight. After release, PCs continue contiguously with no gap or duplicate.
- 3-cycle memory with 2 outstanding (0x8, 0xC) when redirect to 0x100 -> both responses dropped; next fetch_valid shows fetch_pc = 0x100 and the instruction at 0x100.
- Redirect coincident with imem_rsp_valid -> that response is discarded; drop_cnt = outstanding - 1; the first delivered PC is the redirect target.
- redirect_pc = 0x103 -> request address 0x100, fetch_pc = 0x100.
- imem_req_ready low for 3 cycles -> imem_req_addr held constant. Reset asserted with 2 outstanding -> later rsp_valid is ignored and fetch restarts at RESET_PC.
